// File: rtl/iq_symbol_demapper.sv
// I/Q integrate-and-dump symbol demapper with run-time BPSK/QPSK/16-QAM/4-PAM hard slicing
// and a small valid/ready decision FIFO with sticky overflow.
module iq_symbol_demapper #(
    parameter int W          = 5,
    parameter int SPS        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic signed [W-1:0] i_in,
    input  logic signed [W-1:0] q_in,
    input  logic [1:0]          mode,
    input  logic                sym_sync,
    input  logic                sym_ready,
    output logic                sym_valid,
    output logic [3:0]          sym_data,
    output logic [2:0]          sym_bits,
    output logic                overflow
);
    localparam int SW    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int AW    = W + $clog2(SPS) + 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int THR_I = SPS << (W - 2);
    localparam logic signed [AW-1:0] THR  = AW'(THR_I);
    localparam logic [SW-1:0]        LAST = SW'(SPS - 1);
    localparam logic [PW:0]          FULL = (PW+1)'(FIFO_DEPTH);

    // Decision word: {bits[2:0], data[3:0]}; |sum| never reaches the most negative code, so abs is safe.
    function automatic logic [6:0] slice_fn(input logic signed [AW-1:0] si,
                                            input logic signed [AW-1:0] sq,
                                            input logic [1:0] m);
        logic                 i_neg, q_neg, i_inner, q_inner;
        logic signed [AW-1:0] i_abs, q_abs;
        logic [1:0]           pam;
        i_neg   = si[AW-1];
        q_neg   = sq[AW-1];
        i_abs   = i_neg ? -si : si;
        q_abs   = q_neg ? -sq : sq;
        i_inner = (i_abs < THR);
        q_inner = (q_abs < THR);
        if (si < -THR) begin
            pam = 2'b00;
        end else if (i_neg) begin
            pam = 2'b01;
        end else if (si < THR) begin
            pam = 2'b11;
        end else begin
            pam = 2'b10;
        end
        case (m)
            2'b00:   slice_fn = {3'd1, 3'b000, i_neg};
            2'b01:   slice_fn = {3'd2, 2'b00, q_neg, i_neg};
            2'b10:   slice_fn = {3'd4, i_neg, i_inner, q_neg, q_inner};
            2'b11:   slice_fn = {3'd2, 2'b00, pam};
            default: slice_fn = 7'd0;
        endcase
    endfunction

    logic [SW-1:0]        cnt_q, cnt_d, cur_cnt_s;
    logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [AW-1:0] samp_i_s, samp_q_s, sum_i_s, sum_q_s;
    logic [1:0]           mode_q, mode_d, mode_eff_s;
    logic                 first_s;
    logic [6:0]           dec_q, dec_d;
    logic                 dec_valid_q, dec_valid_d;
    logic [6:0]           mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;
    logic                 full_s, pop_s, push_s;
    logic [6:0]           head_s;
    logic                 sym_valid_q, sym_valid_d, overflow_q, overflow_d;
    logic [3:0]           sym_data_q, sym_data_d;
    logic [2:0]           sym_bits_q, sym_bits_d;

    // Integrate-and-dump next state and FIFO bookkeeping
    always_comb begin
        samp_i_s    = AW'(i_in);
        samp_q_s    = AW'(q_in);
        first_s     = sym_sync || (cnt_q == {SW{1'b0}});
        cur_cnt_s   = sym_sync ? {SW{1'b0}} : cnt_q;
        mode_eff_s  = first_s ? mode : mode_q;
        sum_i_s     = first_s ? samp_i_s : acc_i_q + samp_i_s;
        sum_q_s     = first_s ? samp_q_s : acc_q_q + samp_q_s;
        cnt_d       = cnt_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        mode_d      = mode_q;
        dec_d       = dec_q;
        dec_valid_d = 1'b0;
        if (sample_valid) begin
            acc_i_d = sum_i_s;
            acc_q_d = sum_q_s;
            mode_d  = mode_eff_s;
            if (cur_cnt_s == LAST) begin
                cnt_d       = {SW{1'b0}};
                dec_d       = slice_fn(sum_i_s, sum_q_s, mode_eff_s);
                dec_valid_d = 1'b1;
            end else begin
                cnt_d = cur_cnt_s + SW'(1);
            end
        end else if (sym_sync) begin
            cnt_d = {SW{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end

        full_s     = (count_q == FULL);
        pop_s      = sym_valid_q && sym_ready;
        push_s     = dec_valid_q && (!full_s || pop_s);
        overflow_d = overflow_q || (dec_valid_q && full_s && !pop_s);
        wr_ptr_d   = wr_ptr_q + PW'(push_s);
        rd_ptr_d   = rd_ptr_q + PW'(pop_s);
        count_d    = count_q + (PW+1)'(push_s) - (PW+1)'(pop_s);
        // The slot being written is the new head only when the FIFO drains to it this cycle.
        head_s     = (push_s && (wr_ptr_q == rd_ptr_d)) ? dec_q : mem_q[rd_ptr_d];
        if (count_d != {(PW+1){1'b0}}) begin
            sym_valid_d = 1'b1;
            sym_data_d  = head_s[3:0];
            sym_bits_d  = head_s[6:4];
        end else begin
            sym_valid_d = 1'b0;
            sym_data_d  = sym_data_q;
            sym_bits_d  = sym_bits_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= {SW{1'b0}};
            acc_i_q     <= {AW{1'b0}};
            acc_q_q     <= {AW{1'b0}};
            mode_q      <= 2'b00;
            dec_q       <= 7'd0;
            dec_valid_q <= 1'b0;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {(PW+1){1'b0}};
            sym_valid_q <= 1'b0;
            sym_data_q  <= 4'd0;
            sym_bits_q  <= 3'd0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            mode_q      <= mode_d;
            dec_q       <= dec_d;
            dec_valid_q <= dec_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            sym_bits_q  <= sym_bits_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= 7'd0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= dec_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_data  = sym_data_q;
    assign sym_bits  = sym_bits_q;
    assign overflow  = overflow_q;
endmodule
